// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - effect ids, FSM states and the per-effect tone table
package sfx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEG0   = 2'd1,
        SEG1   = 2'd2,
        FINISH = 2'd3
    } sfx_state_e;

    localparam logic [1:0] ID_ERR    = 2'd0;
    localparam logic [1:0] ID_CDOWN  = 2'd1;
    localparam logic [1:0] ID_WORDOK = 2'd2;
    localparam logic [1:0] ID_KEY    = 2'd3;

    localparam int unsigned SIL_DIV = 1;
    localparam int unsigned DUR_W   = 8;

    // Dividers are 50_000_000 / Hz; a zero duration means the segment is absent.
    localparam int unsigned DIV0    [4] = '{151515, 47801, 75757, 47801};
    localparam int unsigned DUR0_MS [4] = '{60, 150, 40, 10};
    localparam int unsigned DIV1    [4] = '{190839, 0, 63775, 0};
    localparam int unsigned DUR1_MS [4] = '{120, 0, 40, 0};

    function automatic logic [1:0] pick_lowest(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic [3:0] id_mask(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

endpackage

// File: rtl/sfx_seg_timer.sv
// rtl/sfx_seg_timer.sv - loadable segment timer, expire marks the last cycle of a segment
module sfx_seg_timer
    import sfx_pkg::*;
#(
    parameter int unsigned CLK_PER_MS = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DUR_W-1:0] len_ms,
    output logic             expire
);

    logic [31:0] count_q;
    logic [31:0] limit_q;
    logic        run_q;

    assign expire = run_q && (count_q == limit_q - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            limit_q <= '0;
            run_q   <= 1'b0;
        end else if (start) begin
            count_q <= '0;
            limit_q <= 32'(len_ms) * 32'(CLK_PER_MS);
            run_q   <= (len_ms != '0);
        end else if (expire) begin
            run_q   <= 1'b0;
        end else if (run_q) begin
            count_q <= count_q + 32'd1;
        end
    end

endmodule

// File: rtl/sfx_arbiter.sv
// rtl/sfx_arbiter.sv - priority arbiter and sequencer sharing note_gen between effects and music
module sfx_arbiter
    import sfx_pkg::*;
#(
    parameter int unsigned CLK_PER_MS = 100000,
    parameter int unsigned DIV_W      = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       req,
    input  logic [DIV_W-1:0] music_div_l,
    input  logic [DIV_W-1:0] music_div_r,
    output logic [DIV_W-1:0] note_div_left,
    output logic [DIV_W-1:0] note_div_right,
    output logic             sfx_active,
    output logic [1:0]       sfx_id,
    output logic             sfx_done
);

    sfx_state_e       state_q, state_d;
    logic [1:0]       cur_id_q, cur_id_d;
    logic [3:0]       pend_q, pend_d;
    logic [DIV_W-1:0] div_l_q, div_r_q;
    logic             active_q, done_q;
    logic [1:0]       id_q;

    logic             tmr_start;
    logic [DUR_W-1:0] tmr_len;
    logic             tmr_expire;
    logic [3:0]       cand;
    logic [3:0]       hi_req;
    logic [1:0]       win;

    sfx_seg_timer #(.CLK_PER_MS(CLK_PER_MS)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (tmr_start),
        .len_ms (tmr_len),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        cur_id_d  = cur_id_q;
        pend_d    = pend_q;
        tmr_start = 1'b0;
        tmr_len   = '0;
        cand      = req | pend_q;
        hi_req    = req & (id_mask(cur_id_q) - 4'd1);
        win       = pick_lowest(cand);
        if (!en) begin
            state_d = IDLE;
            pend_d  = '0;
        end else begin
            case (state_q)
                IDLE, FINISH: begin
                    if (cand != '0) begin
                        state_d   = SEG0;
                        cur_id_d  = win;
                        pend_d    = cand & ~id_mask(win);
                        tmr_start = 1'b1;
                        tmr_len   = DUR_W'(DUR0_MS[win]);
                    end else begin
                        state_d   = IDLE;
                    end
                end
                SEG0, SEG1: begin
                    // A strictly higher-priority request drops the current effect outright.
                    if (hi_req != '0) begin
                        cur_id_d  = pick_lowest(req);
                        pend_d    = (pend_q | req) & ~id_mask(pick_lowest(req));
                        state_d   = SEG0;
                        tmr_start = 1'b1;
                        tmr_len   = DUR_W'(DUR0_MS[pick_lowest(req)]);
                    end else begin
                        pend_d = pend_q | req;
                        if (tmr_expire) begin
                            if (state_q == SEG0 && DUR1_MS[cur_id_q] != 0) begin
                                state_d   = SEG1;
                                tmr_start = 1'b1;
                                tmr_len   = DUR_W'(DUR1_MS[cur_id_q]);
                            end else begin
                                state_d   = FINISH;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_id_q <= 2'd0;
            pend_q   <= '0;
            div_l_q  <= DIV_W'(SIL_DIV);
            div_r_q  <= DIV_W'(SIL_DIV);
            active_q <= 1'b0;
            id_q     <= 2'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            pend_q   <= pend_d;
            case (state_d)
                SEG0: begin
                    div_l_q <= DIV_W'(DIV0[cur_id_d]);
                    div_r_q <= DIV_W'(DIV0[cur_id_d]);
                end
                SEG1: begin
                    div_l_q <= DIV_W'(DIV1[cur_id_d]);
                    div_r_q <= DIV_W'(DIV1[cur_id_d]);
                end
                default: begin
                    div_l_q <= music_div_l;
                    div_r_q <= music_div_r;
                end
            endcase
            active_q <= (state_d == SEG0) || (state_d == SEG1);
            id_q     <= ((state_d == SEG0) || (state_d == SEG1)) ? cur_id_d : 2'd0;
            done_q   <= (state_d == FINISH);
        end
    end

    assign note_div_left  = div_l_q;
    assign note_div_right = div_r_q;
    assign sfx_active     = active_q;
    assign sfx_id         = id_q;
    assign sfx_done       = done_q;

endmodule
